// File: rtl/tnn_serial_frontend.sv
// tnn_serial_frontend: serial-to-parallel front end for a combinational TNN
// classifier. It packs streamed feature beats into a flat vector, holds the
// vector while the classifier settles, captures the prediction and hands it
// off on a registered valid/ready output.
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid && ready are both high. A producer keeps valid and its payload stable
// until that edge. in_ready depends only on the FSM state and rst, never on
// in_valid. out_valid depends only on the FSM state, never on out_ready.
module tnn_serial_frontend #(
  parameter int FEAT_CNT      = 11,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = 7,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_BITS      = 16,
  localparam int PRED_W       = $clog2(CLASS_CNT),
  localparam int VEC_W        = FEAT_CNT * FEAT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FEAT_BITS-1:0] in_data,
  input  logic                 in_last,
  output logic [VEC_W-1:0]     features,
  input  logic [PRED_W-1:0]    pred_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PRED_W-1:0]    out_pred,
  output logic                 frame_err,
  output logic [CNT_BITS-1:0]  frame_cnt,
  output logic [1:0]           dbg_state
);

  localparam int BEAT_W = $clog2(FEAT_CNT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(FEAT_CNT - 1);
  localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  state_t                r_state;
  logic [BEAT_W-1:0]     r_beat;
  logic [7:0]            r_settle;
  logic [VEC_W-1:0]      r_features;
  logic                  r_out_valid;
  logic [PRED_W-1:0]     r_out_pred;
  logic                  r_frame_err;
  logic [CNT_BITS-1:0]   r_frame_cnt;
  logic                  w_in_hs;

  // Beat acceptance is gated by state and by reset itself, so no beat can
  // slip in while rst is held.
  assign in_ready  = (r_state == ST_LOAD) && !rst;
  assign w_in_hs   = in_valid && in_ready;

  assign features  = r_features;
  assign out_valid = r_out_valid;
  assign out_pred  = r_out_pred;
  assign frame_err = r_frame_err;
  assign frame_cnt = r_frame_cnt;
  assign dbg_state = r_state;

  // Main FSM: LOAD packs beats, SETTLE waits for the classifier, OUT hands off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_beat      <= '0;
      r_settle    <= '0;
      r_features  <= '0;
      r_out_valid <= 1'b0;
      r_out_pred  <= '0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_hs) begin
            // First beat ends up in the MSB slice (feature 0).
            r_features <= {r_features[VEC_W-FEAT_BITS-1:0], in_data};
            if (r_beat == LAST_BEAT) begin
              r_beat   <= '0;
              r_settle <= SETTLE_LOAD;
              r_state  <= ST_SETTLE;
              if (!in_last) begin
                r_frame_err <= 1'b1;
              end
            end else if (in_last) begin
              // Short frame: flag it and drop the partial sample.
              r_beat      <= '0;
              r_frame_err <= 1'b1;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (r_settle != 8'd0) begin
            r_settle <= r_settle - 8'd1;
          end else begin
            r_out_pred  <= pred_in;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_frame_cnt <= r_frame_cnt + CNT_BITS'(1);
            r_state     <= ST_LOAD;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_serial_frontend.sv
// Bench for tnn_serial_frontend: streams feature frames, pushes the expected
// prediction per complete frame to a queue and pops it on each output
// handshake. Inputs are driven on the falling edge, outputs sampled there.
module tb_tnn_serial_frontend;

  localparam int FC = 11;
  localparam int FB = 4;
  localparam int CC = 7;
  localparam int SC = 2;
  localparam int CB = 16;
  localparam int PW = $clog2(CC);
  localparam int VW = FC * FB;

  // clock / reset / signals
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FB-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [VW-1:0] features;
  logic [PW-1:0] pred_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] out_pred;
  logic          frame_err;
  logic [CB-1:0] frame_cnt;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  tnn_serial_frontend #(
    .FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(CC),
    .SETTLE_CYCLES(SC), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .features(features), .pred_in(pred_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_pred(out_pred),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // scoreboard state
  int            n_cmp = 0;
  int            n_mis = 0;
  logic [PW-1:0] exp_q[$];
  logic [VW-1:0] exp_feat = '0;
  logic [CB-1:0] exp_fc = '0;
  logic [PW-1:0] mon_e;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // output monitor: pops the queue on every output handshake
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("out_pred", 64'(out_pred), 64'(mon_e));
        end
        exp_fc = exp_fc + 1'b1;
        @(posedge clk); #1;
        check_eq("frame_cnt_hs", 64'(frame_cnt), 64'(exp_fc));
        check_eq("valid_after_hs", 64'(out_valid), 0);
        check_eq("ready_after_hs", 64'(in_ready), 1);
      end
    end
  end

  // driver tasks (entered and left at a falling edge)
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    #1;
    check_eq("ready_in_rst", 64'(in_ready), 0);
    @(negedge clk);
    check_eq("rst_state", 64'(dbg_state), 0);
    check_eq("rst_features", 64'(features), 0);
    check_eq("rst_out_valid", 64'(out_valid), 0);
    check_eq("rst_out_pred", 64'(out_pred), 0);
    check_eq("rst_frame_err", 64'(frame_err), 0);
    check_eq("rst_frame_cnt", 64'(frame_cnt), 0);
    check_eq("rst_in_ready", 64'(in_ready), 0);
    exp_q.delete();
    exp_fc   = '0;
    exp_feat = '0;
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [FB-1:0] d, input logic last);
    int waited = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    #1;
    while (!in_ready && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check_eq("beat_timeout", 0, 1);
      in_valid = 1'b0;
      @(negedge clk);
      return;
    end
    exp_feat = {exp_feat[VW-FB-1:0], d};
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // n beats; in_last on beat last_at (0 = never); counting or random data
  task automatic send_frame(input int n, input int last_at, input bit rnd);
    logic [FB-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? FB'($urandom_range(0, 15)) : FB'(i + 1);
      send_beat(d, (i + 1) == last_at);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain", 64'(exp_q.size()), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_out_valid();
    int w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("out_wait", 64'(out_valid), 1);
  endtask

  // main sequence
  initial begin
    do_reset();

    // counting frame, settle timing and vector layout
    pred_in = 3; out_ready = 1'b1;
    exp_q.push_back(3);
    send_frame(FC, FC, 1'b0);
    check_eq("feat_settle0", 64'(features), 64'h123456789AB);
    check_eq("state_settle", 64'(dbg_state), 1);
    check_eq("valid_e0", 64'(out_valid), 0);
    @(negedge clk);
    check_eq("feat_settle1", 64'(features), 64'h123456789AB);
    check_eq("valid_e1", 64'(out_valid), 0);
    @(negedge clk);
    check_eq("valid_e2", 64'(out_valid), 1);
    check_eq("pred_e2", 64'(out_pred), 3);
    drain();
    check_eq("fc_t1", 64'(frame_cnt), 1);
    check_eq("err_t1", 64'(frame_err), 0);

    // back-pressure with in_valid held high
    out_ready = 1'b0; pred_in = 5;
    exp_q.push_back(5);
    send_frame(FC, FC, 1'b1);
    in_valid = 1'b1; in_data = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", 64'(in_ready), 0);
      check_eq("bp_features", 64'(features), 64'(exp_feat));
      if (out_valid) check_eq("bp_out_pred", 64'(out_pred), 5);
    end
    check_eq("bp_valid", 64'(out_valid), 1);
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_ready_next", 64'(in_ready), 1);
    check_eq("bp_valid_drop", 64'(out_valid), 0);
    drain();
    check_eq("fc_t2", 64'(frame_cnt), 2);

    // early in_last drops the partial frame
    send_frame(5, 5, 1'b1);
    check_eq("early_err", 64'(frame_err), 1);
    check_eq("early_ready", 64'(in_ready), 1);
    check_eq("early_feat", 64'(features), 64'(exp_feat));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("early_no_out", 64'(out_valid), 0);
    end
    pred_in = 4;
    exp_q.push_back(4);
    send_frame(FC, FC, 1'b1);
    drain();
    check_eq("fc_t3", 64'(frame_cnt), 3);
    check_eq("err_sticky", 64'(frame_err), 1);
    check_eq("one_pred", 64'(out_valid), 0);

    // full frame with no in_last still delivers
    do_reset();
    pred_in = 1;
    exp_q.push_back(1);
    send_frame(FC, 0, 1'b1);
    check_eq("nolast_err", 64'(frame_err), 1);
    drain();
    check_eq("fc_t4", 64'(frame_cnt), 1);

    // pred_in changes during SETTLE; capture-cycle value wins
    pred_in = 6;
    exp_q.push_back(2);
    send_frame(FC, FC, 1'b1);
    @(negedge clk);
    pred_in = 2;
    @(negedge clk);
    check_eq("chg_valid", 64'(out_valid), 1);
    check_eq("chg_pred", 64'(out_pred), 2);
    drain();
    check_eq("fc_t5", 64'(frame_cnt), 2);

    // reset mid-frame at beat 7
    send_frame(7, 0, 1'b1);
    do_reset();
    pred_in = 3;
    exp_q.push_back(3);
    send_frame(FC, FC, 1'b1);
    drain();
    check_eq("fc_t6", 64'(frame_cnt), 1);

    // reset while a prediction is pending in OUT
    out_ready = 1'b0; pred_in = 5;
    send_frame(FC, FC, 1'b1);
    wait_out_valid();
    do_reset();
    out_ready = 1'b1; pred_in = 6;
    exp_q.push_back(6);
    send_frame(FC, FC, 1'b1);
    drain();
    check_eq("fc_t7", 64'(frame_cnt), 1);
    check_eq("err_t7", 64'(frame_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
